arb_req_stager: RTL and testbench
=================================

// Module: arb_req_stager
// PURPOSE
//   Upstream request-conditioning stage for the 3-way priority arbiter (r1>r2>r3).
//   Latches one-cycle request pulses from three clients into pending bits and drives r1..r3.
//   Reads back g1..g3 and locks tenure: the granted client keeps ownership until it signals done.
//   A higher-priority request cannot pre-empt the current owner.
// PARAMETERS
//   MAX_HOLD      16   max HOLD cycles per tenure before forced release (>=2)
//   HOLD_W        5    width of hold counter; must hold MAX_HOLD
//   STARVE_LIMIT  32   wait cycles before a pending client is starved (STARVE_GUARD_EN only)
// PORTS
//   clk           in   1  single clock; all state updates on rising edge
//   rst_n         in   1  reset, synchronous, active-low
//   req_pulse     in   3  request pulse; bit0=client1, bit1=client2, bit2=client3
//   done          in   3  end-of-tenure pulse per client; same bit mapping
//   g1,g2,g3      in   1  grants from arbiter (combinational from r1..r3)
//   r1,r2,r3      out  1  requests to arbiter; decoded from registers only, no input->output path
//   owner         out  2  current owner: 0=none, 1..3=client
//   pending       out  3  latched pending requests
//   hold_timeout  out  1  sticky; set when a tenure hits MAX_HOLD
//   grant_err     out  1  sticky; set on a bad grant in ARB
// BEHAVIOUR
//   Reset (rst_n=0 at edge): state=IDLE; pending=0; owner=0; hold_cnt=0; flags=0; r1..r3=0.
//   pending[i]: set by req_pulse[i]; cleared by done[i] when owner==i+1, or by timeout.
//     Pulse while already pending: no effect, no queuing.
//     Same-cycle set and clear on one bit: set wins, bit stays 1.
//     done[i] from a non-owner: ignored.
//   FSM (states IDLE, ARB, HOLD, RELEASE):
//     IDLE: r=000. Go to ARB when pending!=0.
//     ARB: r{i}=pending[i]. Sample g1..g3 in the same cycle.
//       g exactly one-hot and matches a pending bit: owner<=index; hold_cnt<=0; go to HOLD.
//       g=000: stay in ARB.
//       Multi-hot g, or g on a non-pending client: grant_err<=1; stay in ARB.
//       pending becomes 0: go to IDLE.
//     HOLD: only r{owner}=1; all other r=0. hold_cnt increments each cycle.
//       done[owner-1]: clear that pending bit; go to RELEASE.
//       Else hold_cnt==MAX_HOLD-1: clear that pending bit; hold_timeout<=1; go to RELEASE.
//         HOLD therefore lasts at most MAX_HOLD cycles.
//     RELEASE: r=000 for exactly one cycle; owner<=0.
//       Next state is ARB if pending!=0, else IDLE.
//   Latency: pulse at edge N -> pending=1 after N -> ARB (r asserted) after N+1 when in IDLE.
//   hold_cnt never wraps; it is cleared on every entry to HOLD.
//   Reset mid-tenure drops ownership and all pending bits; sticky flags clear only on reset.
// CONFIGURATION
//   STARVE_GUARD_EN defined:
//     wait_cnt[i] increments while pending[i] && owner!=i+1; saturates at STARVE_LIMIT.
//     wait_cnt[i] clears when client i+1 becomes owner or pending[i] clears.
//     In ARB, if any wait_cnt>=STARVE_LIMIT, only the lowest-index starved client is driven.
//   STARVE_GUARD_EN undefined:
//     No wait counters. ARB drives all pending bits, giving pure arbiter priority.
// TESTING
//   1. rst_n=0 for 3 cycles mid-HOLD -> r=000, owner=0, pending=000, flags=0 after the next edge.
//   2. req_pulse=110 -> ARB drives r2=r3=1; g2 -> owner=2, r=010.
//      done=010 -> RELEASE r=000, then ARB r3=1 -> owner=3.
//   3. owner=3 in HOLD, req_pulse=001 -> r1 stays 0 until done[2].
//      Then RELEASE, then owner=1.
//   4. MAX_HOLD=16, owner=2, no done -> RELEASE after 16 HOLD cycles; hold_timeout=1; pending[1]=0.
//   5. owner=1, done=001 and req_pulse=001 same cycle -> pending[0] stays 1; owner=1 again after RELEASE.
//      Also: force g=011 in ARB -> grant_err=1.
//   6. STARVE_GUARD_EN, STARVE_LIMIT=32: client1 re-requests every release, client3 pending.
//      -> first ARB after wait_cnt[2]>=32 drives only r3 -> owner=3.
//      Without the macro, the same stimulus keeps owner=1.

Source files
------------

// File: rtl/arb_req_stager_if.sv
// arb_req_stager_if: client pulses, arbiter grants/requests and status of the request stager
interface arb_req_stager_if;
    logic [2:0] req_pulse;
    logic [2:0] done;
    logic       g1, g2, g3;
    logic       r1, r2, r3;
    logic [1:0] owner;
    logic [2:0] pending;
    logic       hold_timeout;
    logic       grant_err;
    modport master (
        output req_pulse, done, g1, g2, g3,
        input  r1, r2, r3, owner, pending, hold_timeout, grant_err
    );
    modport slave (
        input  req_pulse, done, g1, g2, g3,
        output r1, r2, r3, owner, pending, hold_timeout, grant_err
    );
endinterface

// File: rtl/arb_req_stager.sv
// arb_req_stager: latches client request pulses, drives arbiter requests and locks tenure until done.
// Optional STARVE_GUARD_EN adds per-client wait counters that force a starved client through ARB.
module arb_req_stager #(
    parameter int MAX_HOLD     = 16,
    parameter int HOLD_W       = 5,
    parameter int STARVE_LIMIT = 32
) (
    input logic              clk,
    input logic              rst_n,
    arb_req_stager_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARB  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_REL  = 2'd3;

    if (MAX_HOLD < 2 || MAX_HOLD > 2 ** HOLD_W - 1 || STARVE_LIMIT < 1) begin : g_bad_cfg
        $error("arb_req_stager: invalid MAX_HOLD/HOLD_W/STARVE_LIMIT");
    end

    logic [1:0]        r_state, r_owner;
    logic [2:0]        r_pending;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_hold_timeout, r_grant_err;
    logic [2:0]        w_g, w_own_oh, w_clr, w_arb_r, w_r;
    logic              w_done, w_tmo, w_g_ok;

    assign w_g      = {bus.g3, bus.g2, bus.g1};
    assign w_own_oh = (r_owner == 2'd1) ? 3'b001 : (r_owner == 2'd2) ? 3'b010 :
                      (r_owner == 2'd3) ? 3'b100 : 3'b000;
    assign w_done   = |(bus.done & w_own_oh);
    assign w_tmo    = !w_done && r_hold_cnt == HOLD_W'(MAX_HOLD - 1);
    assign w_clr    = (r_state == S_HOLD && (w_done || w_tmo)) ? w_own_oh : 3'b000;
    assign w_g_ok   = (w_g == 3'b001 || w_g == 3'b010 || w_g == 3'b100) && (w_g & r_pending) == w_g;
    // requests come from registers only, so there is no grant->request loop
    assign w_r      = (r_state == S_ARB) ? w_arb_r : (r_state == S_HOLD) ? w_own_oh : 3'b000;

`ifdef STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    logic [2:0] w_starve;
    for (genvar i = 0; i < 3; i++) begin : g_wait
        logic [WAIT_W-1:0] r_wait;
        always_ff @(posedge clk) begin
            if (!rst_n || !r_pending[i] || r_owner == 2'(i + 1))
                r_wait <= '0;
            else if (r_wait != WAIT_W'(STARVE_LIMIT))
                r_wait <= r_wait + 1'b1;
        end
        assign w_starve[i] = r_wait >= WAIT_W'(STARVE_LIMIT);
    end
    assign w_arb_r = |w_starve ? (w_starve & (~w_starve + 3'd1)) : r_pending;
`else
    assign w_arb_r = r_pending;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_owner        <= 2'd0;
            r_pending      <= 3'b000;
            r_hold_cnt     <= '0;
            r_hold_timeout <= 1'b0;
            r_grant_err    <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | bus.req_pulse;
            case (r_state)
                S_IDLE: if (|r_pending) r_state <= S_ARB;
                S_ARB: begin
                    if (r_pending == 3'b000) begin
                        r_state <= S_IDLE;
                    end else if (w_g_ok) begin
                        r_owner    <= w_g[0] ? 2'd1 : w_g[1] ? 2'd2 : 2'd3;
                        r_hold_cnt <= '0;
                        r_state    <= S_HOLD;
                    end else if (|w_g) begin
                        r_grant_err <= 1'b1;
                    end
                end
                S_HOLD: begin
                    r_hold_cnt <= r_hold_cnt + 1'b1;
                    if (w_done) r_state <= S_REL;
                    if (w_tmo) begin
                        r_hold_timeout <= 1'b1;
                        r_state        <= S_REL;
                    end
                end
                default: begin
                    r_owner <= 2'd0;
                    r_state <= |r_pending ? S_ARB : S_IDLE;
                end
            endcase
        end
    end

    assign {bus.r3, bus.r2, bus.r1} = w_r;
    assign bus.owner        = r_owner;
    assign bus.pending      = r_pending;
    assign bus.hold_timeout = r_hold_timeout;
    assign bus.grant_err    = r_grant_err;
endmodule

// File: tb/tb_arb_req_stager.sv
// tb_arb_req_stager: directed bench with a fixed-priority arbiter model feeding grants back.
module tb_arb_req_stager;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic f_en = 1'b0;
    logic [2:0] f_g = 3'b000;
    logic [2:0] r_vec;
    int checks = 0;
    int errors = 0;

    arb_req_stager_if bus ();

    arb_req_stager #(.MAX_HOLD(16), .HOLD_W(5), .STARVE_LIMIT(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    assign r_vec  = {bus.r3, bus.r2, bus.r1};
    assign bus.g1 = f_en ? f_g[0] : bus.r1;
    assign bus.g2 = f_en ? f_g[1] : (bus.r2 & ~bus.r1);
    assign bus.g3 = f_en ? f_g[2] : (bus.r3 & ~bus.r2 & ~bus.r1);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [2:0] req, input logic [2:0] dn);
        bus.req_pulse = req;
        bus.done      = dn;
        tick();
        bus.req_pulse = 3'b000;
        bus.done      = 3'b000;
    endtask

    task automatic test_reset();
        bus.req_pulse = 3'b000;
        bus.done      = 3'b000;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (r_vec !== 3'b000) begin errors++; $display("FAIL reset_r got=%b exp=000", r_vec); end
        checks++; if (bus.owner !== 2'd0) begin errors++; $display("FAIL reset_owner got=%0d exp=0", bus.owner); end
        checks++; if (bus.pending !== 3'b000) begin errors++; $display("FAIL reset_pending got=%b exp=000", bus.pending); end
        checks++; if ({bus.hold_timeout, bus.grant_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {bus.hold_timeout, bus.grant_err}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_handoff();
        pulse(3'b110, 3'b000);
        checks++; if (bus.pending !== 3'b110) begin errors++; $display("FAIL handoff_pending got=%b exp=110", bus.pending); end
        checks++; if (r_vec !== 3'b000) begin errors++; $display("FAIL handoff_idle_r got=%b exp=000", r_vec); end
        tick();
        checks++; if (r_vec !== 3'b110) begin errors++; $display("FAIL handoff_arb_r got=%b exp=110", r_vec); end
        tick();
        checks++; if (bus.owner !== 2'd2) begin errors++; $display("FAIL handoff_owner2 got=%0d exp=2", bus.owner); end
        checks++; if (r_vec !== 3'b010) begin errors++; $display("FAIL handoff_hold_r got=%b exp=010", r_vec); end
        pulse(3'b000, 3'b010);
        checks++; if (r_vec !== 3'b000) begin errors++; $display("FAIL handoff_release_r got=%b exp=000", r_vec); end
        checks++; if (bus.pending !== 3'b100) begin errors++; $display("FAIL handoff_release_pending got=%b exp=100", bus.pending); end
        tick();
        checks++; if (r_vec !== 3'b100) begin errors++; $display("FAIL handoff_arb3_r got=%b exp=100", r_vec); end
        tick();
        checks++; if (bus.owner !== 2'd3) begin errors++; $display("FAIL handoff_owner3 got=%0d exp=3", bus.owner); end
    endtask

    task automatic test_no_preempt();
        pulse(3'b001, 3'b000);
        checks++; if (bus.pending !== 3'b101) begin errors++; $display("FAIL nopre_pending got=%b exp=101", bus.pending); end
        tick();
        checks++; if (r_vec !== 3'b100 || bus.owner !== 2'd3) begin errors++; $display("FAIL nopre_hold got r=%b owner=%0d exp r=100 owner=3", r_vec, bus.owner); end
        pulse(3'b000, 3'b001);
        checks++; if (bus.owner !== 2'd3 || bus.pending !== 3'b101) begin errors++; $display("FAIL nopre_foreign_done got owner=%0d pending=%b exp 3/101", bus.owner, bus.pending); end
        pulse(3'b000, 3'b100);
        checks++; if (r_vec !== 3'b000 || bus.pending !== 3'b001) begin errors++; $display("FAIL nopre_release got r=%b pending=%b exp 000/001", r_vec, bus.pending); end
        tick();
        checks++; if (r_vec !== 3'b001) begin errors++; $display("FAIL nopre_arb_r got=%b exp=001", r_vec); end
        tick();
        checks++; if (bus.owner !== 2'd1) begin errors++; $display("FAIL nopre_owner1 got=%0d exp=1", bus.owner); end
        pulse(3'b000, 3'b001);
        tick();
        checks++; if (bus.owner !== 2'd0 || r_vec !== 3'b000) begin errors++; $display("FAIL nopre_idle got owner=%0d r=%b exp 0/000", bus.owner, r_vec); end
    endtask

    task automatic test_timeout();
        pulse(3'b010, 3'b000);
        tick();
        tick();
        checks++; if (bus.owner !== 2'd2) begin errors++; $display("FAIL tmo_owner got=%0d exp=2", bus.owner); end
        repeat (15) tick();
        checks++; if (r_vec !== 3'b010 || bus.hold_timeout !== 1'b0) begin errors++; $display("FAIL tmo_still_hold got r=%b tmo=%b exp 010/0", r_vec, bus.hold_timeout); end
        tick();
        checks++; if (r_vec !== 3'b000) begin errors++; $display("FAIL tmo_release_r got=%b exp=000", r_vec); end
        checks++; if (bus.hold_timeout !== 1'b1) begin errors++; $display("FAIL tmo_flag got=%b exp=1", bus.hold_timeout); end
        checks++; if (bus.pending[1] !== 1'b0) begin errors++; $display("FAIL tmo_pending got=%b exp=0", bus.pending[1]); end
        tick();
        checks++; if (bus.owner !== 2'd0 || r_vec !== 3'b000) begin errors++; $display("FAIL tmo_idle got owner=%0d r=%b exp 0/000", bus.owner, r_vec); end
    endtask

    task automatic test_same_cycle_and_grant_err();
        pulse(3'b001, 3'b000);
        tick();
        tick();
        checks++; if (bus.owner !== 2'd1) begin errors++; $display("FAIL same_owner got=%0d exp=1", bus.owner); end
        pulse(3'b001, 3'b001);
        checks++; if (bus.pending !== 3'b001 || r_vec !== 3'b000) begin errors++; $display("FAIL same_set_wins got pending=%b r=%b exp 001/000", bus.pending, r_vec); end
        tick();
        tick();
        checks++; if (bus.owner !== 2'd1) begin errors++; $display("FAIL same_owner_again got=%0d exp=1", bus.owner); end
        pulse(3'b000, 3'b001);
        tick();
        pulse(3'b110, 3'b000);
        tick();
        f_en = 1'b1;
        f_g  = 3'b011;
        tick();
        checks++; if (bus.grant_err !== 1'b1) begin errors++; $display("FAIL gerr_flag got=%b exp=1", bus.grant_err); end
        checks++; if (bus.owner !== 2'd0 || r_vec !== 3'b110) begin errors++; $display("FAIL gerr_stay_arb got owner=%0d r=%b exp 0/110", bus.owner, r_vec); end
        f_en = 1'b0;
        f_g  = 3'b000;
        tick();
        checks++; if (bus.owner !== 2'd2) begin errors++; $display("FAIL gerr_recover got=%0d exp=2", bus.owner); end
    endtask

    task automatic test_reset_mid_hold();
        rst_n = 1'b0;
        tick();
        checks++; if (r_vec !== 3'b000 || bus.owner !== 2'd0) begin errors++; $display("FAIL rst_hold got r=%b owner=%0d exp 000/0", r_vec, bus.owner); end
        checks++; if (bus.pending !== 3'b000) begin errors++; $display("FAIL rst_hold_pending got=%b exp=000", bus.pending); end
        checks++; if ({bus.hold_timeout, bus.grant_err} !== 2'b00) begin errors++; $display("FAIL rst_hold_flags got=%b exp=00", {bus.hold_timeout, bus.grant_err}); end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_starvation();
        int n1 = 0;
        logic saw3 = 1'b0;
        pulse(3'b101, 3'b000);
        for (int k = 0; k < 16 && !saw3; k++) begin
            int w = 0;
            while (bus.owner == 2'd0 && w < 10) begin
                tick();
                w++;
            end
            if (bus.owner == 2'd0) begin
                errors++;
                $display("FAIL starve_wait_owner timed out at tenure %0d", k);
                break;
            end
            if (bus.owner == 2'd1) n1++;
            if (bus.owner == 2'd3) saw3 = 1'b1;
            pulse(bus.owner == 2'd1 ? 3'b001 : 3'b000, bus.owner == 2'd1 ? 3'b001 : 3'b100);
            tick();
        end
`ifdef STARVE_GUARD_EN
        checks++; if (saw3 !== 1'b1) begin errors++; $display("FAIL starve_guard got saw_owner3=%b exp=1", saw3); end
`else
        checks++; if (n1 != 16 || saw3 !== 1'b0) begin errors++; $display("FAIL starve_none got owner1_tenures=%0d saw3=%b exp 16/0", n1, saw3); end
`endif
    endtask

    initial begin
        test_reset();
        test_handoff();
        test_no_preempt();
        test_timeout();
        test_same_cycle_and_grant_err();
        test_reset_mid_hold();
        test_starvation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
